i2c_txn_arbiter: RTL and testbench

Round-robin scheduler that shares one I2C byte-transaction master between NUM_REQ requesters. Each requester posts a single register transaction (slave address, register address, data, direction). The block grants one requester, latches its command, and launches it on the master. It then waits for completion, retries on NACK and enforces a timeout. It sits between client logic (sensor/config FSMs) and the I2C master datapath, and is the only driver of the master's enable/address/data inputs.

---
 rtl/i2c_txn_arbiter_if.sv | 46 ++++
 rtl/i2c_txn_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_txn_arbiter_if.sv
// rtl/i2c_txn_arbiter_if.sv - requester and I2C master signal bundle for i2c_txn_arbiter
interface i2c_txn_arbiter_if #(
  parameter int NUM_REQ = 2
);

  // Requester side
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   req_rw;
  logic [7*NUM_REQ-1:0] req_slave_addr;
  logic [8*NUM_REQ-1:0] req_reg_addr;
  logic [8*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [NUM_REQ-1:0]   err;
  logic                 err_timeout;
  logic [7:0]           rdata;

  // I2C byte-transaction master side
  logic                 m_enable;
  logic [6:0]           m_slave_addr;
  logic [7:0]           m_reg_addr;
  logic [7:0]           m_data;
  logic                 m_read_write;
  logic                 m_abort;
  logic                 m_busy;
  logic                 m_done;
  logic                 m_nack;
  logic [7:0]           m_rdata;

  // Arbiter view: consumes requests and master status, drives grants and master commands
  modport master (
    input  req, req_rw, req_slave_addr, req_reg_addr, req_wdata,
    input  m_busy, m_done, m_nack, m_rdata,
    output gnt, done, err, err_timeout, rdata,
    output m_enable, m_slave_addr, m_reg_addr, m_data, m_read_write, m_abort
  );

  // Environment view: requesters plus the I2C master datapath
  modport slave (
    output req, req_rw, req_slave_addr, req_reg_addr, req_wdata,
    output m_busy, m_done, m_nack, m_rdata,
    input  gnt, done, err, err_timeout, rdata,
    input  m_enable, m_slave_addr, m_reg_addr, m_data, m_read_write, m_abort
  );

endinterface

// File: rtl/i2c_txn_arbiter.sv
// rtl/i2c_txn_arbiter.sv - round-robin scheduler sharing one I2C byte-transaction master
module i2c_txn_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_RETRY = 3,
  parameter int RETRY_GAP = 16,
  parameter int TIMEOUT   = 1023
) (
  input logic               clk,
  input logic               reset,
  i2c_txn_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_GAP    = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     g_q, g_d;
  logic [RTY_W-1:0]     retry_cnt_q, retry_cnt_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [NUM_REQ-1:0]   err_q, err_d;
  logic                 err_timeout_q, err_timeout_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 m_enable_q, m_enable_d;
  logic                 m_abort_q, m_abort_d;
  logic [6:0]           m_slave_addr_q, m_slave_addr_d;
  logic [7:0]           m_reg_addr_q, m_reg_addr_d;
  logic [7:0]           m_data_q, m_data_d;
  logic                 m_read_write_q, m_read_write_d;

  logic                 arb_found;
  logic [PTR_W-1:0]     arb_sel;

  // Requester index base+off, wrapped into 0..NUM_REQ-1 (off < NUM_REQ)
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return PTR_W'(sum);
  endfunction

  // Round-robin pick: scan downward so the smallest offset from rr_ptr is the one that sticks
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req[wrap_add(rr_ptr_q, i)]) begin
        arb_found = 1'b1;
        arb_sel   = wrap_add(rr_ptr_q, i);
      end
    end
  end

  // Next-state and next-output logic; pulses default low so they last one cycle
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    g_d            = g_q;
    retry_cnt_d    = retry_cnt_q;
    timer_d        = timer_q;
    gap_cnt_d      = gap_cnt_q;
    gnt_d          = gnt_q;
    rdata_d        = rdata_q;
    m_slave_addr_d = m_slave_addr_q;
    m_reg_addr_d   = m_reg_addr_q;
    m_data_d       = m_data_q;
    m_read_write_d = m_read_write_q;
    done_d         = '0;
    err_d          = '0;
    err_timeout_d  = 1'b0;
    m_enable_d     = 1'b0;
    m_abort_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A busy master (e.g. another bus user finishing) holds off arbitration entirely
        if (arb_found && !bus.m_busy) begin
          gnt_d          = '0;
          gnt_d[arb_sel] = 1'b1;
          g_d            = arb_sel;
          retry_cnt_d    = '0;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_sel == PTR_W'(i)) begin
              m_slave_addr_d = bus.req_slave_addr[7*i +: 7];
              m_reg_addr_d   = bus.req_reg_addr[8*i +: 8];
              m_data_d       = bus.req_wdata[8*i +: 8];
              m_read_write_d = bus.req_rw[i];
            end
          end
          state_d = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        m_enable_d = 1'b1;
        timer_d    = '0;
        state_d    = S_WAIT;
      end

      S_WAIT: begin
        timer_d = timer_q + 1'b1;
        // Completion is checked before the timeout so a late m_done still counts
        if (bus.m_done) begin
          if (!bus.m_nack) begin
            done_d = gnt_q;
            if (!m_read_write_q) rdata_d = bus.m_rdata;
            state_d = S_RESP;
          end else if (retry_cnt_q < RTY_W'(MAX_RETRY)) begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            gap_cnt_d   = '0;
            state_d     = (RETRY_GAP == 0) ? S_LAUNCH : S_GAP;
          end else begin
            err_d         = gnt_q;
            err_timeout_d = 1'b0;
            state_d       = S_RESP;
          end
        end else if (timer_q == TMR_W'(TIMEOUT)) begin
          m_abort_d     = 1'b1;
          err_d         = gnt_q;
          err_timeout_d = 1'b1;
          state_d       = S_RESP;
        end
      end

      S_GAP: begin
        // Grant and latched command stay put; stray m_done here is ignored
        if (gap_cnt_q == GAP_W'(RETRY_GAP - 1)) begin
          state_d = S_LAUNCH;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      S_RESP: begin
        // Terminal pulse is visible this cycle; the winner drops to lowest priority
        gnt_d    = '0;
        rr_ptr_d = wrap_add(g_q, 1);
        state_d  = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // All state and outputs are registered; asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      g_q            <= '0;
      retry_cnt_q    <= '0;
      timer_q        <= '0;
      gap_cnt_q      <= '0;
      gnt_q          <= '0;
      done_q         <= '0;
      err_q          <= '0;
      err_timeout_q  <= 1'b0;
      rdata_q        <= '0;
      m_enable_q     <= 1'b0;
      m_abort_q      <= 1'b0;
      m_slave_addr_q <= '0;
      m_reg_addr_q   <= '0;
      m_data_q       <= '0;
      m_read_write_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      g_q            <= g_d;
      retry_cnt_q    <= retry_cnt_d;
      timer_q        <= timer_d;
      gap_cnt_q      <= gap_cnt_d;
      gnt_q          <= gnt_d;
      done_q         <= done_d;
      err_q          <= err_d;
      err_timeout_q  <= err_timeout_d;
      rdata_q        <= rdata_d;
      m_enable_q     <= m_enable_d;
      m_abort_q      <= m_abort_d;
      m_slave_addr_q <= m_slave_addr_d;
      m_reg_addr_q   <= m_reg_addr_d;
      m_data_q       <= m_data_d;
      m_read_write_q <= m_read_write_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.err_timeout  = err_timeout_q;
  assign bus.rdata        = rdata_q;
  assign bus.m_enable     = m_enable_q;
  assign bus.m_abort      = m_abort_q;
  assign bus.m_slave_addr = m_slave_addr_q;
  assign bus.m_reg_addr   = m_reg_addr_q;
  assign bus.m_data       = m_data_q;
  assign bus.m_read_write = m_read_write_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// tb/tb_i2c_txn_arbiter.sv - randomized self-checking bench for i2c_txn_arbiter
module tb_i2c_txn_arbiter;

  localparam int NR = 2;
  localparam int MR = 3;
  localparam int RG = 16;
  localparam int TO = 1023;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  i2c_txn_arbiter_if #(.NUM_REQ(NR)) bus_if ();

  i2c_txn_arbiter #(
    .NUM_REQ  (NR),
    .MAX_RETRY(MR),
    .RETRY_GAP(RG),
    .TIMEOUT  (TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level reference model
  bit         pend [NR];
  logic [6:0] c_sa [NR];
  logic [7:0] c_ra [NR];
  logic [7:0] c_wd [NR];
  bit         c_rw [NR];
  int         rr        = 0;
  logic [7:0] exp_rdata = 8'h00;
  int         keep_mode = 0;
  int         last_w    = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic post_cmd(input int i, input logic [6:0] sa, input logic [7:0] ra,
                          input logic [7:0] wd, input bit rw);
    c_sa[i] = sa;
    c_ra[i] = ra;
    c_wd[i] = wd;
    c_rw[i] = rw;
    pend[i] = 1'b1;
    bus_if.req_slave_addr[7*i +: 7] = sa;
    bus_if.req_reg_addr[8*i +: 8]   = ra;
    bus_if.req_wdata[8*i +: 8]      = wd;
    bus_if.req_rw[i]                = rw;
    bus_if.req[i]                   = 1'b1;
  endtask

  task automatic post(input int i);
    post_cmd(i, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  // Next winner: first pending requester at or after rr, wrapping
  function automatic int pick();
    int w;
    w = -1;
    for (int k = NR - 1; k >= 0; k--) begin
      if (pend[(rr + k) % NR]) w = (rr + k) % NR;
    end
    return w;
  endfunction

  // One whole transaction: nacks NACKed attempts, then ACK, or silence when silent=1.
  // nacks > MR means every attempt is NACKed and the error path is expected.
  task automatic run_txn(input int nacks, input bit silent, input int fix_lat,
                         input int fix_rd, input bit chk_lat);
    int         w, polls, prev_en, att, lat;
    bit         got, nk, stray;
    logic [6:0] sa;
    logic [7:0] ra, wd, rd;
    bit         rw;
    w = pick();
    if (w < 0) begin
      chk("no_pending", 0, 1);
      return;
    end
    got   = 1'b0;
    polls = 0;
    while (!got && polls < 40) begin
      @(negedge clk);
      polls++;
      if (bus_if.gnt != '0) got = 1'b1;
    end
    chk("gnt", bus_if.gnt, 64'(1 << w));
    if (!got) return;
    if (chk_lat) chk("gnt_lat", polls, 1);
    last_w = w;
    sa = c_sa[w];
    ra = c_ra[w];
    wd = c_wd[w];
    rw = c_rw[w];
    // Requester side changes after grant must not reach the master
    if ($urandom_range(0, 1) == 1) begin
      bus_if.req_slave_addr[7*w +: 7] = ~sa;
      bus_if.req_reg_addr[8*w +: 8]   = ~ra;
      bus_if.req_wdata[8*w +: 8]      = ~wd;
      bus_if.req_rw[w]                = ~rw;
    end
    if ($urandom_range(0, 3) == 0) bus_if.req[w] = 1'b0;
    att     = silent ? nacks + 1 : ((nacks > MR) ? MR + 1 : nacks + 1);
    prev_en = 0;
    for (int a = 0; a < att; a++) begin
      got   = 1'b0;
      polls = 0;
      while (!got && polls < RG + 40) begin
        @(negedge clk);
        polls++;
        if (bus_if.m_enable) got = 1'b1;
      end
      chk("m_enable", got, 1);
      if (!got) return;
      chk("m_cmd", {bus_if.m_slave_addr, bus_if.m_reg_addr, bus_if.m_data, bus_if.m_read_write},
          {sa, ra, wd, rw});
      chk("gnt_hold", bus_if.gnt, 64'(1 << w));
      if (a == 0) chk("en_lat", polls, 1);
      else        chk("retry_gap", (cyc - prev_en) >= RG + 1, 1);
      prev_en = cyc;
      if (silent && a == att - 1) begin
        got   = 1'b0;
        polls = 0;
        while (!got && polls < TO + 20) begin
          @(negedge clk);
          polls++;
          if (bus_if.err != '0) got = 1'b1;
        end
        chk("to_dist", polls, TO + 1);
        chk("to_err", bus_if.err, 64'(1 << w));
        chk("to_flag", bus_if.err_timeout, 1);
        chk("to_abort", bus_if.m_abort, 1);
        chk("to_nodone", bus_if.done, 0);
        chk("gnt_term", bus_if.gnt, 64'(1 << w));
      end else begin
        nk    = (a < nacks);
        stray = ($urandom_range(0, 1) == 1);
        lat   = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 30));
        rd    = (fix_rd >= 0) ? 8'(fix_rd) : 8'($urandom);
        for (int k = 0; k < lat; k++) begin
          bus_if.m_nack = stray && (k == 1);
          @(negedge clk);
        end
        bus_if.m_done  = 1'b1;
        bus_if.m_nack  = nk;
        bus_if.m_rdata = rd;
        @(negedge clk);
        bus_if.m_done = 1'b0;
        bus_if.m_nack = 1'b0;
        if (a == att - 1) begin
          if (nk) begin
            chk("nack_err", bus_if.err, 64'(1 << w));
            chk("nack_flag", bus_if.err_timeout, 0);
            chk("nack_nodone", bus_if.done, 0);
          end else begin
            chk("done", bus_if.done, 64'(1 << w));
            chk("done_noerr", bus_if.err, 0);
            if (!rw) exp_rdata = rd;
            chk("rdata", bus_if.rdata, exp_rdata);
          end
          chk("gnt_term", bus_if.gnt, 64'(1 << w));
        end else begin
          chk("retry_quiet", {bus_if.done, bus_if.err}, 0);
          if (stray) begin
            bus_if.m_done  = 1'b1;
            bus_if.m_rdata = 8'($urandom);
            @(negedge clk);
            bus_if.m_done = 1'b0;
          end
        end
      end
    end
    rr      = (w + 1) % NR;
    pend[w] = 1'b0;
    if (keep_mode == 1 || (keep_mode == 0 && $urandom_range(0, 2) == 0)) post(w);
    else bus_if.req[w] = 1'b0;
    @(negedge clk);
    chk("gnt_drop", bus_if.gnt, 0);
    chk("pulse_drop", {bus_if.done, bus_if.err}, 0);
    chk("rdata_hold", bus_if.rdata, exp_rdata);
  endtask

  // Per-cycle invariants: terminal pulses and launch never coincide, grant is one-hot
  always @(negedge clk) begin
    if (reset && (bus_if.m_enable || bus_if.done != '0 || bus_if.err != '0))
      chk("excl", $countones({bus_if.m_enable, bus_if.done, bus_if.err}), 1);
    if (reset && bus_if.gnt != '0)
      chk("gnt_onehot", $countones(bus_if.gnt), 1);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int polls;
    bit got;
    bus_if.req            = '0;
    bus_if.req_rw         = '0;
    bus_if.req_slave_addr = '0;
    bus_if.req_reg_addr   = '0;
    bus_if.req_wdata      = '0;
    bus_if.m_busy         = 1'b0;
    bus_if.m_done         = 1'b0;
    bus_if.m_nack         = 1'b0;
    bus_if.m_rdata        = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_out", {bus_if.gnt, bus_if.done, bus_if.err, bus_if.err_timeout, bus_if.m_enable,
                    bus_if.m_abort, bus_if.m_slave_addr, bus_if.m_reg_addr, bus_if.m_data,
                    bus_if.m_read_write, bus_if.rdata}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_gnt", bus_if.gnt, 0);

    // Directed single write
    keep_mode = 2;
    post_cmd(0, 7'h50, 8'h10, 8'hA5, 1'b1);
    run_txn(0, 1'b0, 40, -1, 1'b1);

    // Busy master blocks arbitration
    bus_if.m_busy = 1'b1;
    post(0);
    repeat (4) begin
      @(negedge clk);
      chk("busy_block", bus_if.gnt, 0);
    end
    bus_if.m_busy = 1'b0;
    run_txn(0, 1'b0, -1, -1, 1'b1);

    // Directed read on requester 1
    post_cmd(1, 7'h21, 8'h44, 8'h00, 1'b0);
    run_txn(0, 1'b0, -1, 8'h3C, 1'b1);
    chk("rdata_3c", bus_if.rdata, 8'h3C);

    // Round-robin with both requests held
    keep_mode = 1;
    post(0);
    post(1);
    for (int k = 0; k < 4; k++) begin
      run_txn(0, 1'b0, -1, -1, 1'b0);
      chk("rr_order", last_w, k % 2);
    end

    // NACK on every attempt
    keep_mode = 2;
    run_txn(MR + 1, 1'b0, -1, -1, 1'b0);
    chk("nack_who", last_w, 0);

    // Timeout on requester 1, then requester 0 served
    post(0);
    run_txn(0, 1'b1, -1, -1, 1'b0);
    chk("to_who", last_w, 1);
    run_txn(0, 1'b0, -1, -1, 1'b0);
    chk("after_to", last_w, 0);

    // Asynchronous reset mid-WAIT; arbitration restarts from requester 0
    post(0);
    got   = 1'b0;
    polls = 0;
    while (!got && polls < 20) begin
      @(negedge clk);
      polls++;
      if (bus_if.m_enable) got = 1'b1;
    end
    chk("rst_pre_en", got, 1);
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_async", {bus_if.gnt, bus_if.done, bus_if.err, bus_if.err_timeout, bus_if.m_enable,
                         bus_if.m_abort, bus_if.m_slave_addr, bus_if.m_reg_addr, bus_if.m_data,
                         bus_if.m_read_write, bus_if.rdata}, 0);
    post(1);
    rr        = 0;
    exp_rdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_txn(0, 1'b0, -1, -1, 1'b1);
    chk("rst_rr0", last_w, 0);
    run_txn(0, 1'b0, -1, -1, 1'b0);
    chk("rst_next", last_w, 1);

    // Randomized traffic
    keep_mode = 0;
    for (int it = 0; it < 30; it++) begin
      int r, nk;
      bit sil, any;
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) post(i);
      end
      any = 1'b0;
      for (int i = 0; i < NR; i++) any = any | pend[i];
      if (!any) post(int'($urandom_range(0, NR - 1)));
      r   = int'($urandom_range(0, 9));
      nk  = (r < 6) ? 0 : ((r < 8) ? int'($urandom_range(1, MR)) : MR + 1);
      sil = (it == 9 || it == 21);
      if (sil && nk > MR) nk = MR;
      run_txn(nk, sil, -1, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
